pcpu_muldiv_unit: RTL and testbench

Iterative RV32M/RV64M multiply/divide execution unit. It is a parametrised successor to the single-cycle ALU path of the 5-stage pipelined CPU. The unit sits in the EX stage beside the ALU. While it computes, it holds `busy` high so the hazard logic stalls IF/ID/ID-EX. It returns its result with the destination register tag for the EX/MEM register. The pipeline flush logic can abort an operation in flight.

---
 rtl/pcpu_muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_pcpu_muldiv_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpu_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pcpu_muldiv_unit
//  Description : Iterative RV32M/RV64M multiply/divide unit for the EX stage.
//                Shift-add multiply (MUL_BITS multiplier bits per cycle) and
//                restoring divide (one quotient bit per cycle) on operand
//                magnitudes, with sign correction in a final FIX cycle.
//                Divide-by-zero and signed overflow finish in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcpu_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             reset,     // asynchronous, active low
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] C_MUL_LAST = CNT_W'(XLEN / MUL_BITS - 1);
    localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  C_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;     // multiplicand |a| or divisor |b|
    logic [2*XLEN-1:0]   acc_q, acc_d;       // {hi, lo}: product or {rem, quo}
    logic                neg_q, neg_d;       // product / quotient negative
    logic                rneg_q, rneg_d;     // remainder negative (dividend sign)
    logic [CNT_W-1:0]    count_q, count_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [TAG_W-1:0]    tag_q, tag_d;

    logic                w_accept;
    logic                w_sa, w_sb, w_a_neg, w_b_neg;
    logic [XLEN-1:0]     w_a_mag, w_b_mag;
    logic                w_div_zero, w_div_ovf, w_special;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN+MUL_BITS-1:0] w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_shift, w_div_diff;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo, w_rem, w_fix_result;
    logic                w_last;

    // Operand decode at accept: signedness, magnitudes and one-cycle cases
    always_comb begin
        w_sa          = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        w_sb          = op[2] ? ~op[0] : ~op[1];
        w_a_neg       = w_sa & a[XLEN-1];
        w_b_neg       = w_sb & b[XLEN-1];
        w_a_mag       = w_a_neg ? -a : a;
        w_b_mag       = w_b_neg ? -b : b;
        w_div_zero    = op[2] & (b == '0);
        w_div_ovf     = op[2] & ~op[0] & (a == C_MOST_NEG) & (b == '1);
        w_special     = w_div_zero | w_div_ovf;
        // op[1] selects remainder among the divide ops
        if (w_div_zero) begin
            w_special_res = op[1] ? a : '1;
        end else begin
            w_special_res = op[1] ? '0 : a;
        end
    end

    // Iteration datapath and final sign correction / output selection
    always_comb begin
        // Multiply: add multiplicand * low digit into the high half, then
        // shift the whole accumulator right by one digit.
        w_mul_sum   = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                    + ({{MUL_BITS{1'b0}}, opnd_q} * {{XLEN{1'b0}}, acc_q[MUL_BITS-1:0]});
        w_mul_next  = {w_mul_sum, acc_q[XLEN-1:MUL_BITS]};

        // Divide: shift next dividend bit into the partial remainder and
        // keep the subtraction only if it did not go negative.
        w_div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, opnd_q};
        w_div_next  = w_div_diff[XLEN]
                    ? {w_div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                    : {w_div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

        w_prod = neg_q  ? -acc_q : acc_q;
        w_quo  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        w_rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        case (op_q)
            3'b000:                 w_fix_result = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_result = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_result = w_quo;
            default:                w_fix_result = w_rem;
        endcase

        w_last = op_q[2] ? (count_q == C_DIV_LAST) : (count_q == C_MUL_LAST);
    end

    // Next-state and register-update logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        count_d  = count_q;
        result_d = result_q;
        tag_d    = tag_q;

        w_accept = start & ~kill & ((state_q == S_IDLE) | (state_q == S_DONE));

        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_CALC: begin
                    acc_d   = op_q[2] ? w_div_next : w_mul_next;
                    count_d = count_q + CNT_W'(1);
                    if (w_last) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d = w_fix_result;
                    state_d  = S_DONE;
                end
                default: begin
                    // IDLE and DONE both accept; DONE otherwise returns to IDLE
                    state_d = S_IDLE;
                    if (w_accept) begin
                        op_d    = op;
                        tag_d   = tag_in;
                        neg_d   = w_a_neg ^ w_b_neg;
                        rneg_d  = w_a_neg;
                        count_d = '0;
                        opnd_d  = op[2] ? w_b_mag : w_a_mag;
                        acc_d   = {{XLEN{1'b0}}, (op[2] ? w_a_mag : w_b_mag)};
                        if (w_special) begin
                            result_d = w_special_res;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_CALC;
                        end
                    end
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            count_q  <= count_d;
            result_q <= result_d;
            tag_q    <= tag_d;
        end
    end

    assign busy    = (state_q == S_CALC) | (state_q == S_FIX);
    assign done    = (state_q == S_DONE);
    assign result  = result_q;
    assign tag_out = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_pcpu_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcpu_muldiv_unit
//  Description : Self-checking bench for pcpu_muldiv_unit: behavioural
//                latency/result model, per-cycle compare, directed cases
//                and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcpu_muldiv_unit;

    localparam int XLEN      = 32;
    localparam int MUL_BITS  = 4;
    localparam int TAG_W     = 5;
    localparam int C_MUL_LAT = XLEN / MUL_BITS + 2;
    localparam int C_DIV_LAT = XLEN + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             kill;
    logic [2:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag_in;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pcpu_muldiv_unit #(
        .XLEN     (XLEN),
        .MUL_BITS (MUL_BITS),
        .TAG_W    (TAG_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .tag_in  (tag_in),
        .kill    (kill),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .tag_out (tag_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an RV32M instruction
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x,
                                               input logic [31:0] y);
        logic [63:0] p;
        int          sx;
        int          sy;
        sx = x;
        sy = y;
        case (f)
            3'b000: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'b001: begin p = longint'(sx) * longint'(sy); return p[63:32]; end
            3'b010: begin p = longint'(sx) * longint'({32'b0, y}); return p[63:32]; end
            3'b011: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'b100: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return sx / sy;
            end
            3'b101: return (y == 32'h0) ? 32'hFFFF_FFFF : x / y;
            3'b110: begin
                if (y == 32'h0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return sx % sy;
            end
            default: return (y == 32'h0) ? x : x % y;
        endcase
    endfunction

    // Cycles from the accepting edge to the done cycle
    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] x,
                                       input logic [31:0] y);
        if (!f[2]) return C_MUL_LAT;
        if (y == 32'h0) return 1;
        if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return C_DIV_LAT;
    endfunction

    // Behavioural model: a remaining-cycles counter and the pending answer
    int               m_left;
    logic             m_done;
    logic [31:0]      m_result;
    logic [31:0]      m_pend;
    logic [TAG_W-1:0] m_tag;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_result <= '0;
            m_pend   <= '0;
            m_tag    <= '0;
        end else if (kill) begin
            m_left <= 0;
            m_done <= 1'b0;
        end else if (start && m_left == 0) begin
            m_tag  <= tag_in;
            m_pend <= ref_result(op, a, b);
            if (ref_latency(op, a, b) == 1) begin
                m_result <= ref_result(op, a, b);
                m_done   <= 1'b1;
                m_left   <= 0;
            end else begin
                m_left <= ref_latency(op, a, b) - 1;
                m_done <= 1'b0;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_result <= m_pend;
        end else begin
            m_done <= 1'b0;
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        check("cyc busy",   64'(busy),    64'(m_left != 0));
        check("cyc done",   64'(done),    64'(m_done));
        check("cyc result", 64'(result),  64'(m_result));
        check("cyc tag",    64'(tag_out), 64'(m_tag));
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom % 8)
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op from idle and wait (bounded) for its done pulse
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [TAG_W-1:0] t,
                          input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        start  = 1'b1;
        op     = f;
        a      = x;
        b      = y;
        tag_in = t;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, 64'(cyc),     64'(exp_lat));
        check({name, " result"},  64'(result),  64'(exp_res));
        check({name, " tag"},     64'(tag_out), 64'(t));
        @(posedge clk); #1;
    endtask

    initial begin
        int   cyc;
        logic seen;
        reset  = 1'b0;
        start  = 1'b0;
        kill   = 1'b0;
        op     = '0;
        a      = '0;
        b      = '0;
        tag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   64'(busy),    64'h0);
        check("reset done",   64'(done),    64'h0);
        check("reset result", 64'(result),  64'h0);
        check("reset tag",    64'(tag_out), 64'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Hand-computed values pinning the reference model
        check("model MUL",    64'(ref_result(3'b000, 32'd7, 32'hFFFF_FFFD)),        64'hFFFF_FFEB);
        check("model MULH",   64'(ref_result(3'b001, 32'h8000_0000, 32'h8000_0000)), 64'h4000_0000);
        check("model MULHU",  64'(ref_result(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFE);
        check("model MULHSU", 64'(ref_result(3'b010, 32'hFFFF_FFFF, 32'd2)),        64'hFFFF_FFFF);
        check("model REM",    64'(ref_result(3'b110, 32'hFFFF_FFF9, 32'd2)),        64'hFFFF_FFFF);
        check("model DIV",    64'(ref_result(3'b100, 32'hFFFF_FFF9, 32'd2)),        64'hFFFF_FFFD);

        // Directed cases
        run_op("MUL",     3'b000, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 10);
        run_op("MULH",    3'b001, 32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, 10);
        run_op("MULHU",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 10);
        run_op("MULHSU",  3'b010, 32'hFFFF_FFFF,  32'd2,         5'd6,  32'hFFFF_FFFF, 10);
        run_op("DIVU",    3'b101, 32'd100,        32'd7,         5'd7,  32'd14,        34);
        run_op("REM",     3'b110, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 34);
        run_op("DIV",     3'b100, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 34);
        run_op("DIV ovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
        run_op("DIVU 0",  3'b101, 32'hDEAD_BEEF,  32'h0,         5'd11, 32'hFFFF_FFFF, 1);
        run_op("REMU 0",  3'b111, 32'h0000_1234,  32'h0,         5'd12, 32'h0000_1234, 1);

        // Kill a divide in flight
        start  = 1'b1;
        op     = 3'b100;
        a      = 32'd100;
        b      = 32'd7;
        tag_in = 5'd13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill busy",   64'(busy),   64'h0);
        check("kill result", 64'(result), 64'h0000_1234);
        seen = 1'b0;
        repeat (40) begin
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("kill no done", 64'(seen),   64'h0);
        check("kill held",    64'(result), 64'h0000_1234);
        run_op("MUL after kill", 3'b000, 32'd6, 32'd7, 5'd14, 32'd42, 10);

        // Start held high through CALC (ignored) and DONE (accepted)
        start  = 1'b1;
        op     = 3'b000;
        a      = 32'd3;
        b      = 32'd5;
        tag_in = 5'd1;
        @(posedge clk); #1;
        a      = 32'd6;
        b      = 32'd9;
        tag_in = 5'd2;
        cyc    = 1;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b first latency", 64'(cyc),     64'd10);
        check("b2b first result",  64'(result),  64'd15);
        check("b2b first tag",     64'(tag_out), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b accepted busy", 64'(busy), 64'h1);
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b second latency", 64'(cyc),     64'd10);
        check("b2b second result",  64'(result),  64'd54);
        check("b2b second tag",     64'(tag_out), 64'd2);
        @(posedge clk); #1;

        // Reset asserted mid-calculation
        start  = 1'b1;
        op     = 3'b000;
        a      = 32'd5;
        b      = 32'd5;
        tag_in = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midreset busy",   64'(busy),    64'h0);
        check("midreset done",   64'(done),    64'h0);
        check("midreset result", 64'(result),  64'h0);
        check("midreset tag",    64'(tag_out), 64'h0);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic; the per-cycle compare does the checking
        repeat (4000) begin
            start  = ($urandom % 3) == 0;
            kill   = ($urandom % 50) == 0;
            op     = 3'($urandom);
            a      = pick_operand();
            b      = pick_operand();
            tag_in = TAG_W'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        kill  = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
